// File: rtl/router_switch_allocator_pkg.sv
// Shared definitions for the XY-router switch allocator: port encoding,
// default sizing, flit field positions and the per-output FSM states.
package router_switch_allocator_pkg;

    localparam int DEF_NUM_PORTS = 5;
    localparam int DEF_SEL_W     = 3;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_S = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    // Destination coordinates inside a head flit, consumed by XY route compute.
    localparam int FLIT_DEST_X_HI = 9;
    localparam int FLIT_DEST_X_LO = 5;
    localparam int FLIT_DEST_Y_HI = 4;
    localparam int FLIT_DEST_Y_LO = 0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

endpackage

// File: rtl/router_switch_allocator_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr, cyclically,
// and returns it both one-hot and as an index.
module router_switch_allocator_rr_arbiter
    import router_switch_allocator_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_W-1:0]     grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/router_switch_allocator.sv
// Packet-level switch allocator: one round-robin arbiter and IDLE/LOCKED FSM
// per output, holding the crossbar path until the tail flit transfers.
module router_switch_allocator
    import router_switch_allocator_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PORTS-1:0]       in_valid,
    input  logic [NUM_PORTS*SEL_W-1:0] in_dest_port,
    input  logic [NUM_PORTS-1:0]       in_tail,
    output logic [NUM_PORTS-1:0]       in_ready,
    output logic [NUM_PORTS-1:0]       out_valid,
    output logic [NUM_PORTS*SEL_W-1:0] out_sel,
    input  logic [NUM_PORTS-1:0]       out_ready,
    output logic [NUM_PORTS-1:0]       out_busy,
    output logic                       err_bad_port
);

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] p);
        if (int'(p) >= NUM_PORTS - 1) return '0;
        return p + 1'b1;
    endfunction

    logic [SEL_W-1:0]     dest  [NUM_PORTS];
    logic [SEL_W-1:0]     owner [NUM_PORTS];
    logic [NUM_PORTS-1:0] locked;
    logic [NUM_PORTS-1:0] owns_any;
    logic [NUM_PORTS-1:0] bad_req;

    // An owning input's destination field is ignored, so it never raises an error.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        assign dest[i]    = in_dest_port[i*SEL_W +: SEL_W];
        assign bad_req[i] = in_valid[i] && !owns_any[i] && (int'(dest[i]) >= NUM_PORTS);
    end

    always_comb begin
        owns_any = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (locked[o]) owns_any[owner[o]] = 1'b1;
        end
    end

    assign err_bad_port = rst_n && (|bad_req);

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        out_state_e           state;
        logic [SEL_W-1:0]     owner_q;
        logic [SEL_W-1:0]     ptr_q;
        logic [SEL_W-1:0]     grant_idx;
        logic [NUM_PORTS-1:0] req;
        logic [NUM_PORTS-1:0] grant;
        logic                 tail_xfer;

        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
            assign req[i] = in_valid[i] && !owns_any[i] && (dest[i] == SEL_W'(o));
        end

        router_switch_allocator_rr_arbiter #(
            .NUM_PORTS (NUM_PORTS),
            .SEL_W     (SEL_W)
        ) u_arb (
            .req       (req),
            .ptr       (ptr_q),
            .grant     (grant),
            .grant_idx (grant_idx)
        );

        assign tail_xfer = in_valid[owner_q] && out_ready[o] && in_tail[owner_q];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= ST_IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (|grant) begin
                            owner_q <= grant_idx;
                            state   <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (tail_xfer) begin
                            state <= ST_IDLE;
                            ptr_q <= wrap_inc(owner_q);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign owner[o]  = owner_q;
        assign locked[o] = (state == ST_LOCKED);
    end

    // Crossbar selects and handshakes are decoded from the lock state so an
    // asynchronous reset clears them in the same cycle.
    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_sel   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (locked[o]) begin
                out_valid[o]                = in_valid[owner[o]];
                out_sel[o*SEL_W +: SEL_W]   = owner[o];
                if (out_ready[o] && in_valid[owner[o]]) in_ready[owner[o]] = 1'b1;
            end
        end
    end

    assign out_busy = locked;

endmodule
